qam_prbs_sequencer: RTL

//  Sequences the 13-bit PRBS LFSR (taps 12,3,2,0) feeding the QAM modulator. Loads a seed,

---
 rtl/qam_prbs_sequencer_if.sv | 12 +
 rtl/qam_prbs_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/qam_prbs_sequencer_if.sv
// Symbol handshake between the PRBS sequencer (master) and the constellation mapper (slave).
interface qam_prbs_sequencer_if #(
  parameter int BITS_PER_SYM = 4
) ();
  logic [BITS_PER_SYM-1:0] sym_data;
  logic                    sym_valid;
  logic                    sym_ready;
  logic                    sym_last;

  modport master (output sym_data, output sym_valid, output sym_last, input sym_ready);
  modport slave  (input sym_data, input sym_valid, input sym_last, output sym_ready);
endinterface

// File: rtl/qam_prbs_sequencer.sv
// Steps an external 13-bit PRBS LFSR, packs BITS_PER_SYM bits per symbol (first bit = MSB)
// and delivers fixed-length frames to the QAM mapper over a valid/ready handshake.
module qam_prbs_sequencer #(
  parameter int                BITS_PER_SYM = 4,
  parameter int                FRAME_LEN    = 64,
  parameter int                LFSR_W       = 13,
  parameter logic [LFSR_W-1:0] SEED         = 13'h000F
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [LFSR_W-1:0]   cfg_seed,
  input  logic                cfg_seed_we,
  input  logic                lfsr_bit,
  output logic                lfsr_step,
  output logic                lfsr_load,
  output logic [LFSR_W-1:0]   lfsr_seed,
  qam_prbs_sequencer_if.master sym,
  output logic                busy,
  output logic                frame_done
);

  localparam int BCW = $clog2(BITS_PER_SYM);
  localparam int SCW = $clog2(FRAME_LEN + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BITS_PER_SYM - 1);
  localparam logic [SCW-1:0] SYM_LAST = SCW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_FILL,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [LFSR_W-1:0]       seed_reg;
  logic [BCW-1:0]          bit_cnt;
  logic [SCW-1:0]          sym_cnt;
  logic [BITS_PER_SYM-2:0] shift_q;
  logic [BITS_PER_SYM-1:0] sym_data_q;
  logic [BITS_PER_SYM-1:0] shift_next;

  assign shift_next = {shift_q, lfsr_bit};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !abort) state_d = S_SEED;
      S_SEED: state_d = abort ? S_IDLE : S_FILL;
      S_FILL: begin
        if (abort)                    state_d = S_IDLE;
        else if (bit_cnt == BIT_LAST) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (abort)              state_d = S_IDLE;
        else if (sym.sym_ready) state_d = (sym_cnt == SYM_LAST) ? S_DONE : S_FILL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seed_reg   <= SEED;
      bit_cnt    <= '0;
      sym_cnt    <= '0;
      shift_q    <= '0;
      sym_data_q <= '0;
    end else begin
      // An all-zero seed would lock the LFSR up, so it falls back to SEED.
      if (cfg_seed_we) seed_reg <= (cfg_seed == '0) ? SEED : cfg_seed;
      case (state_q)
        S_IDLE: if (start && !abort) sym_cnt <= '0;
        S_SEED: bit_cnt <= '0;
        S_FILL: begin
          if (!abort) begin
            shift_q <= shift_next[BITS_PER_SYM-2:0];
            if (bit_cnt == BIT_LAST) begin
              sym_data_q <= shift_next;
              bit_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_HOLD: if (!abort && sym.sym_ready) sym_cnt <= sym_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Everything below is decoded from registered state; sym_ready never reaches sym_valid.
  assign lfsr_load     = (state_q == S_SEED);
  assign lfsr_step     = (state_q == S_FILL);
  assign lfsr_seed     = seed_reg;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);
  assign sym.sym_valid = (state_q == S_HOLD);
  assign sym.sym_last  = (state_q == S_HOLD) && (sym_cnt == SYM_LAST);
  assign sym.sym_data  = sym_data_q;

endmodule
